// File: rtl/univ_sr_pkg.sv
// Shared types for the universal shift register: operation modes,
// control FSM states and a small mode-classification helper.
package univ_sr_pkg;

  // Operation select; codes 6 and 7 are unused and treated as HOLD.
  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_SHR  = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_LOAD = 3'd3,
    MODE_ROTR = 3'd4,
    MODE_ROTL = 3'd5
  } sr_mode_e;

  // Control FSM: IDLE until the first LOAD, ACTIVE while counting,
  // FULL once WIDTH shifts have been counted.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } sr_state_e;

  // True for the four modes that move data by one bit position.
  function automatic logic is_move(input logic [2:0] mode);
    return (mode == MODE_SHR)  || (mode == MODE_SHL) ||
           (mode == MODE_ROTR) || (mode == MODE_ROTL);
  endfunction

endpackage

// File: rtl/univ_sr_ctrl.sv
// Control FSM for the universal shift register: counts shifts/rotates
// since the last LOAD (saturating at WIDTH) and emits a registered
// one-cycle done pulse when the count first reaches WIDTH.
module univ_sr_ctrl import univ_sr_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] LP_CNT_FULL = CNT_W'(WIDTH);

  sr_state_e        r_state;
  sr_state_e        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_done;
  logic             w_done_next;
  logic             w_move;

  assign w_move = is_move(mode_i);

  // State, counter and done pulse registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state, next-count and done decode; HOLD/invalid codes keep everything.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    if (mode_i == MODE_LOAD) begin
      w_state_next = ST_ACTIVE;
      w_cnt_next   = '0;
    end else if (w_move) begin
      case (r_state)
        ST_ACTIVE: begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_cnt_next == LP_CNT_FULL) begin
            w_state_next = ST_FULL;
            w_done_next  = 1'b1;
          end
        end
        ST_FULL: begin
          // Data keeps moving in the datapath; the count stays pinned.
          w_cnt_next = LP_CNT_FULL;
        end
        default: begin
          // IDLE: moves are not counted until a LOAD has happened.
          w_state_next = r_state;
        end
      endcase
    end
  end

  assign cnt_o  = r_cnt;
  assign done_o = r_done;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left with serial inputs,
// rotate right/left and parallel load, plus a shift counter with a
// done pulse (in univ_sr_ctrl).
// Optional feature: define SR_PARITY_EN to add a registered even-parity
// output parity_o covering all register bits.
module univ_shift_reg import univ_sr_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode_i,
  input  logic             sin_r_i,
  input  logic             sin_l_i,
  input  logic [WIDTH-1:0] pdata_i,
  output logic [WIDTH-1:0] sr_o,
  output logic             sout_r_o,
  output logic             sout_l_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
`ifdef SR_PARITY_EN
  ,
  output logic             parity_o
`endif
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_next;

  // Next register value selected by the operation mode.
  always_comb begin
    w_sr_next = r_sr;
    case (mode_i)
      MODE_SHR:  w_sr_next = {sin_r_i, r_sr[WIDTH-1:1]};
      MODE_SHL:  w_sr_next = {r_sr[WIDTH-2:0], sin_l_i};
      MODE_ROTR: w_sr_next = {r_sr[0], r_sr[WIDTH-1:1]};
      MODE_ROTL: w_sr_next = {r_sr[WIDTH-2:0], r_sr[WIDTH-1]};
      MODE_LOAD: w_sr_next = pdata_i;
      default:   w_sr_next = r_sr;
    endcase
  end

  // Data register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr <= '0;
    end else begin
      r_sr <= w_sr_next;
    end
  end

  assign sr_o     = r_sr;
  assign sout_r_o = r_sr[0];
  assign sout_l_o = r_sr[WIDTH-1];

`ifdef SR_PARITY_EN
  logic r_parity;

  // Parity computed from the next value so it updates with sr_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ^w_sr_next;
    end
  end

  assign parity_o = r_parity;
`endif

  univ_sr_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .mode_i (mode_i),
    .cnt_o  (cnt_o),
    .done_o (done_o)
  );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg at WIDTH=8: a directed vector
// table, hand-written multi-cycle sequences and randomized stimulus
// compared against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [2:0]       mode_i;
  logic             sin_r_i;
  logic             sin_l_i;
  logic [WIDTH-1:0] pdata_i;
  logic [WIDTH-1:0] sr_o;
  logic             sout_r_o;
  logic             sout_l_o;
  logic [CNT_W-1:0] cnt_o;
  logic             done_o;
`ifdef SR_PARITY_EN
  logic             parity_o;
`endif

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode_i   (mode_i),
    .sin_r_i  (sin_r_i),
    .sin_l_i  (sin_l_i),
    .pdata_i  (pdata_i),
    .sr_o     (sr_o),
    .sout_r_o (sout_r_o),
    .sout_l_o (sout_l_o),
    .cnt_o    (cnt_o),
    .done_o   (done_o)
`ifdef SR_PARITY_EN
    ,
    .parity_o (parity_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: value, moves counted since last LOAD, whether a LOAD
  // has occurred since reset, and whether this cycle should show done.
  int m_sr;
  int m_cnt;
  bit m_loaded;
  bit m_done;

  typedef struct {
    logic [2:0] mode;
    bit         sinr;
    bit         sinl;
    logic [7:0] pdata;
    logic [7:0] exp_sr;
    int         exp_cnt;
    bit         exp_done;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sr = 0; m_cnt = 0; m_loaded = 0; m_done = 0;
  endtask

  task automatic model_update(input logic [2:0] m, input bit sr_in, input bit sl_in, input logic [7:0] pd);
    bit moved;
    m_done = 0;
    moved  = 1;
    case (m)
      3'd1: m_sr = (m_sr >> 1) | (int'(sr_in) << 7);
      3'd2: m_sr = ((m_sr << 1) & 255) | int'(sl_in);
      3'd4: m_sr = (m_sr >> 1) | ((m_sr & 1) << 7);
      3'd5: m_sr = ((m_sr << 1) & 255) | (m_sr >> 7);
      3'd3: begin m_sr = int'(pd); m_cnt = 0; m_loaded = 1; moved = 0; end
      default: moved = 0;
    endcase
    if (moved && m_loaded && m_cnt < WIDTH) begin
      m_cnt++;
      if (m_cnt == WIDTH) m_done = 1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".sr"},     64'(sr_o),     64'(m_sr));
    check({tag, ".cnt"},    64'(cnt_o),    64'(m_cnt));
    check({tag, ".done"},   64'(done_o),   64'(m_done));
    check({tag, ".sout_r"}, 64'(sout_r_o), 64'(m_sr & 1));
    check({tag, ".sout_l"}, 64'(sout_l_o), 64'((m_sr >> 7) & 1));
`ifdef SR_PARITY_EN
    check({tag, ".parity"}, 64'(parity_o), 64'($countones(m_sr[7:0]) & 1));
`endif
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [2:0] m, input bit sr_in, input bit sl_in, input logic [7:0] pd);
    mode_i = m; sin_r_i = sr_in; sin_l_i = sl_in; pdata_i = pd;
    @(posedge clk);
    #1;
    model_update(m, sr_in, sl_in, pd);
    $display("txn mode=%0d sinr=%0d sinl=%0d pd=%02h -> sr=%02h cnt=%0d done=%0d",
             m, sr_in, sl_in, pd, sr_o, cnt_o, done_o);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    model_reset();
    check("rst.sr",   64'(sr_o),   64'h0);
    check("rst.cnt",  64'(cnt_o),  64'h0);
    check("rst.done", 64'(done_o), 64'h0);
`ifdef SR_PARITY_EN
    check("rst.parity", 64'(parity_o), 64'h0);
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode_i = 3'd0; sin_r_i = 1'b0; sin_l_i = 1'b0; pdata_i = '0;
    model_reset();

    vecs[0] = '{3'd3, 1'b0, 1'b0, 8'hA5, 8'hA5, 0, 1'b0};
    vecs[1] = '{3'd1, 1'b1, 1'b0, 8'h00, 8'hD2, 1, 1'b0};
    vecs[2] = '{3'd3, 1'b0, 1'b0, 8'h81, 8'h81, 0, 1'b0};
    vecs[3] = '{3'd5, 1'b0, 1'b0, 8'h00, 8'h03, 1, 1'b0};
    vecs[4] = '{3'd3, 1'b0, 1'b0, 8'h81, 8'h81, 0, 1'b0};
    vecs[5] = '{3'd4, 1'b0, 1'b0, 8'h00, 8'hC0, 1, 1'b0};
    vecs[6] = '{3'd3, 1'b0, 1'b0, 8'h3C, 8'h3C, 0, 1'b0};
    vecs[7] = '{3'd7, 1'b1, 1'b1, 8'hFF, 8'h3C, 0, 1'b0};
    vecs[8] = '{3'd7, 1'b0, 1'b1, 8'h00, 8'h3C, 0, 1'b0};
    vecs[9] = '{3'd7, 1'b1, 1'b0, 8'h55, 8'h3C, 0, 1'b0};

    // Power-up reset held for a couple of cycles.
    repeat (2) @(posedge clk);
    #1;
    check("por.sr",   64'(sr_o),   64'h0);
    check("por.cnt",  64'(cnt_o),  64'h0);
    check("por.done", 64'(done_o), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // IDLE after reset: shifting moves data but does not count.
    step(3'd1, 1'b1, 1'b0, 8'h00);
    check("idle.shr.cnt", 64'(cnt_o), 64'h0);
    check_model("idle.shr");

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      if (i == 1) check("sout_r_pre_shr", 64'(sout_r_o), 64'h1);
      step(vecs[i].mode, vecs[i].sinr, vecs[i].sinl, vecs[i].pdata);
      check($sformatf("vec%0d.sr", i),   64'(sr_o),   64'(vecs[i].exp_sr));
      check($sformatf("vec%0d.cnt", i),  64'(cnt_o),  64'(vecs[i].exp_cnt));
      check($sformatf("vec%0d.done", i), 64'(done_o), 64'(vecs[i].exp_done));
      check_model($sformatf("vec%0d", i));
    end

    // LOAD then 9 SHL: done only after the 8th, count saturates at 8.
    step(3'd3, 1'b0, 1'b0, 8'h5A);
    for (int k = 1; k <= 9; k++) begin
      step(3'd2, 1'b0, k[0], 8'h00);
      check($sformatf("shl%0d.done", k), 64'(done_o), (k == 8) ? 64'h1 : 64'h0);
      check($sformatf("shl%0d.cnt", k),  64'(cnt_o),  (k >= 8) ? 64'h8 : 64'(k));
      check_model($sformatf("shl%0d", k));
    end
    // LOAD from FULL restarts the count.
    step(3'd3, 1'b0, 1'b0, 8'h11);
    check("reload.cnt", 64'(cnt_o), 64'h0);

    // Reset mid-count at cnt=5, then SHR does not count.
    for (int k = 0; k < 5; k++) step(3'd1, 1'b0, 1'b0, 8'h00);
    check("mid.cnt5", 64'(cnt_o), 64'h5);
    do_reset();
    step(3'd1, 1'b1, 1'b0, 8'h00);
    check("post_rst.shr.sr",  64'(sr_o),  64'h80);
    check("post_rst.shr.cnt", 64'(cnt_o), 64'h0);

`ifdef SR_PARITY_EN
    step(3'd3, 1'b0, 1'b0, 8'h07);
    check("par.load07", 64'(parity_o), 64'h1);
    step(3'd2, 1'b0, 1'b0, 8'h00);
    check("par.shl.sr", 64'(sr_o),     64'h0E);
    check("par.shl",    64'(parity_o), 64'h1);
`endif

    // Randomized stimulus against the reference model; LOAD kept rare so
    // the count regularly reaches saturation.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] m;
      if ($urandom_range(0, 19) == 0) m = 3'd3;
      else begin
        m = 3'($urandom_range(0, 7));
        if (m == 3'd3) m = 3'd1;
      end
      step(m, 1'($urandom), 1'($urandom), 8'($urandom));
      check_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
